mdu_ctrl: RTL and testbench

- Multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, runs a fixed-latency busy countdown, and commits HI/LO on completion.
- Drives the E_Busy stall term consumed by D-stage hazard logic.
- Suppresses issue when IntReq flushes the E-stage instruction.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_arith.sv | 49 ++++
 rtl/mdu_ctrl.sv | 117 +++++++++++
 tb/tb_mdu_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Ops that start a multi-cycle countdown and therefore stall D.
  function automatic logic is_md_start(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_mult(logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MIPS multiply/divide datapath producing the 64-bit {hi,lo} result.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  // Signed divide; the single overflow case is pinned to the architectural result.
  function automatic logic [63:0] sdiv(logic [31:0] x, logic [31:0] y);
    logic signed [31:0] xs, ys, q, r;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    xs = signed'(x);
    ys = signed'(y);
    q  = xs / ys;
    r  = xs % ys;
    return {r, q};
  endfunction

  logic signed [63:0] a_s, b_s;
  logic        [63:0] a_u, b_u;

  assign a_s = {{32{a[31]}}, a};
  assign b_s = {{32{b[31]}}, b};
  assign a_u = {32'h0, a};
  assign b_u = {32'h0, b};

  always_comb begin
    result      = 64'h0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = 64'(a_s * b_s);
      MD_MULTU: result = a_u * b_u;
      MD_DIV: begin
        if (b == 32'h0) div_by_zero = 1'b1;
        else            result = sdiv(a, b);
      end
      MD_DIVU: begin
        if (b == 32'h0) div_by_zero = 1'b1;
        else            result = {a % b, a / b};
      end
      default: result = 64'h0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: fixed-latency countdown, HI/LO commit, stall term.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        E_Busy,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata,
  output logic        done
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d;
  logic [31:0]      hi_d, lo_d;
  logic [63:0]      shadow_q, shadow_d;
  logic             dz_q, dz_d;
  logic [63:0]      arith_res;
  logic             arith_dz;

  mdu_arith u_arith (
    .op          (md_op),
    .a           (rs_data),
    .b           (rt_data),
    .result      (arith_res),
    .div_by_zero (arith_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'h0;
      lo       <= 32'h0;
      shadow_q <= 64'h0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      hi       <= hi_d;
      lo       <= lo_d;
      shadow_q <= shadow_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy;
    done_d   = 1'b0;
    hi_d     = hi;
    lo_d     = lo;
    shadow_d = shadow_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (!IntReq) begin
          if (is_md_start(md_op)) begin
            shadow_d = arith_res;
            dz_d     = arith_dz;
            cnt_d    = is_md_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_d   = 1'b1;
            state_d  = S_RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_RUN: begin
        // An in-flight op is older than any faulting instruction, so IntReq never aborts it.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!dz_q) begin
            hi_d = shadow_q[63:32];
            lo_d = shadow_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign E_Busy = is_md_start(md_op) || busy;

  always_comb begin
    md_rdata = 32'h0;
    if (md_op == MD_MFHI)      md_rdata = hi;
    else if (md_op == MD_MFLO) md_rdata = lo;
  end

  illegal_op_while_busy: assert property (@(posedge clk) disable iff (reset)
    busy |-> (md_op == MD_NONE || md_op == MD_MFHI || md_op == MD_MFLO));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a scoreboard queue holds expected {hi,lo} for each done pulse.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntReq;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        E_Busy, busy, done;
  logic [31:0] hi, lo, md_rdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .IntReq   (IntReq),
    .md_op    (md_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .E_Busy   (E_Busy),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata),
    .done     (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 with hi=%h lo=%h, want no pulse", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("commit_hi", hi, e[63:32]);
        chk("commit_lo", lo, e[31:0]);
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(posedge clk); #1;
    md_op = op; rs_data = a; rt_data = b;
    @(negedge clk);
    chk({name, "_issue_ebusy"}, {31'h0, E_Busy}, 32'h1);
    exp_q.push_back({ehi, elo});
    @(posedge clk); #1;
    md_op = MD_NONE;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      if (E_Busy !== 1'b1) chk({name, "_busy_ebusy"}, {31'h0, E_Busy}, 32'h1);
    end
    chk({name, "_busy_cycles"}, n, cycles);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    md_op = op; rs_data = v;
    @(posedge clk); #1;
    md_op = MD_NONE;
  endtask

  task automatic rd(input string name, input logic [3:0] op, input logic [31:0] exp);
    @(posedge clk); #1;
    md_op = op;
    @(negedge clk);
    chk(name, md_rdata, exp);
  endtask

  initial begin
    int seen_busy;
    reset = 1'b1; IntReq = 1'b0; md_op = MD_NONE; rs_data = 0; rt_data = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_ebusy", {31'h0, E_Busy}, 32'h0);

    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    rd("mfhi_mult", MD_MFHI, 32'hFFFF_FFFF);
    rd("mflo_mult", MD_MFLO, 32'hFFFF_FFFE);
    rd("rdata_none", MD_NONE, 32'h0);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_negneg", MD_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5, 32'h0, 32'h6);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negdivisor", MD_DIV, 32'h7, 32'hFFFF_FFFE, 10, 32'h1, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'h7, 32'h2, 10, 32'h1, 32'h3);

    // Flushed MULT must leave no trace; following MTLO still lands.
    @(posedge clk); #1;
    md_op = MD_MULT; rs_data = 32'h1234_5678; rt_data = 32'h10; IntReq = 1'b1;
    @(posedge clk); #1;
    IntReq = 1'b0; md_op = MD_MTLO; rs_data = 32'h1234;
    @(negedge clk);
    seen_busy = int'(busy);
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(negedge clk);
    seen_busy += int'(busy);
    chk("intreq_busy", seen_busy, 0);
    chk("intreq_hi", hi, 32'h1);
    chk("mtlo_lo", lo, 32'h1234);

    mt(MD_MTHI, 32'hAAAA);
    @(negedge clk);
    chk("mthi_hi", hi, 32'hAAAA);
    chk("mthi_nobusy", {31'h0, busy}, 32'h0);
    run_op("divu_zero", MD_DIVU, 32'h5, 32'h0, 10, 32'hAAAA, 32'h1234);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // Reset during the third busy cycle of a MULT aborts it with no done pulse.
    @(posedge clk); #1;
    md_op = MD_MULT; rs_data = 32'h3; rt_data = 32'h3;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", {31'h0, busy}, 32'h0);
    chk("midrun_rst_hi", hi, 32'h0);
    chk("midrun_rst_lo", lo, 32'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrun_rst_busy_later", {31'h0, busy}, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
